instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer end of the decode interface: fetches 32-bit RISC-V instructions from instruction memory and presents each one, with its PC and opcode field, to decode/control over a valid/ready handshake.
- Owns the PC, a small in-order instruction buffer and branch redirect.
- Sits between instruction memory and the opcode decoder.

Parameters:
ADDR_WIDTH, 32, width of PC and memory addresses
RESET_PC, 0, first fetch address after reset (must be 4-aligned)
FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory requests (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  ADDR_WIDTH  fetch address (current PC)
imem_resp_valid  input  1  response data valid
imem_resp_data  input  32  instruction word, returned in request order
branch_taken  input  1  redirect request, single-cycle pulse
branch_target  input  ADDR_WIDTH  redirect address
instr_valid  output  1  buffer head valid
instr_ready  input  1  decode consumes head this cycle
instr  output  32  head instruction word
instr_pc  output  ADDR_WIDTH  PC of head instruction
opcode  output  7  instr[6:0], to control decode

Behaviour:
- Reset (reset high at an edge): state=BOOT, pc=RESET_PC, outstanding=0, FIFO empty. imem_req_valid=0, instr_valid=0, instr/instr_pc/opcode=0. Reset overrides every other input, including mid-transaction; responses to pre-reset requests are not handled and memory is reset alongside.
- States:
  - BOOT: one idle cycle, then RUN.
  - RUN: normal fetch.
  - DRAIN: discards stale responses after a redirect.
- Request rule (RUN only):
  - imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH); it never depends on imem_req_ready.
  - imem_req_addr = pc.
  - On accept (valid & ready): pc <= pc+4 (wraps modulo 2^ADDR_WIDTH), outstanding+1.
- Response rule: memory returns responses in order, earliest one cycle after the request is accepted.
  - In RUN: write {data, pc of that request} to the FIFO tail and decrement outstanding. The request rule guarantees space is always available.
  - In DRAIN: discard the response and decrement outstanding.
- Output:
  - instr_valid = FIFO not empty; instr/instr_pc/opcode come from the head, combinationally.
  - Pop on instr_valid & instr_ready.
  - Fall-through latency: response cycle N -> instr_valid at cycle N+1.
  - Head is stable while instr_valid & !instr_ready.
- Redirect (branch_taken=1, any state except BOOT):
  - pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00}.
  - FIFO flushed; a pop in the same cycle still counts as consumed.
  - A response arriving in the same cycle is discarded.
  - A request accepted in the same cycle counts as outstanding and will be dropped; pc takes the target, not pc+4.
  - Next state is DRAIN if outstanding (after that cycle's updates) > 0, else RUN.
- DRAIN: no requests issued; instr_valid=0. Go to RUN in the cycle after outstanding reaches 0. A further redirect in DRAIN updates pc and stays in DRAIN.
- Boundaries:
  - FIFO full plus outstanding = FIFO_DEPTH -> request withheld.
  - Simultaneous push and pop on a full FIFO is legal.
  - Push and pop on an empty FIFO do not bypass; the 1-cycle latency holds.

Optional Feature:
OPCODE_FILTER_EN
- Defined:
  - Adds output illegal_instr (1 bit, reset 0).
  - On FIFO push, any opcode not in {0110011, 0000011, 0100011, 1100011} is replaced by 0x00000033 (add x0,x0,x0) with an illegal flag stored alongside.
  - illegal_instr = head flag & instr_valid.
- Undefined: words are passed unchanged; no illegal_instr port.

Test Plan:
1. Reset, memory always ready with 1-cycle response returning 0x00000033 -> requests at 0x0, 0x4, 0x8...; instr_valid first high 3 cycles after reset deasserts; instr_pc increments by 4; opcode=0110011.
2. Hold instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) requests issued, head holds PC 0x0 stable; release -> sustained one instruction per cycle.
3. branch_taken with branch_target=0x103 while 2 requests are outstanding -> DRAIN; 2 responses dropped; next request at 0x100; first delivered instr_pc=0x100.
4. branch_taken in the same cycle as a request accept at 0x8 and a response for 0x4 -> the 0x4 response is dropped; the 0x8 request is dropped later; fetch resumes at the target.
5. Assert reset mid-DRAIN with outstanding=1 -> next cycle all outputs 0, pc=RESET_PC, BOOT.
6. With OPCODE_FILTER_EN, return 0x00000013 -> instr=0x00000033, illegal_instr=1 while at the head; 0x00002003 passes with illegal_instr=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: producer end of the decode interface.
// Owns the PC, issues in-order fetches to instruction memory, buffers returned
// words in a small FIFO and presents the head to decode over valid/ready.
// A taken branch flushes the buffer and drains stale in-flight responses.
// Optional build macro: OPCODE_FILTER_EN (replaces unsupported opcodes with
// add x0,x0,x0 and raises illegal_instr while such a word is at the head).
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [6:0]            opcode
`ifdef OPCODE_FILTER_EN
  ,
  output logic                  illegal_instr
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [CNT_W-1:0]      r_outstanding, w_outstanding_next;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [31:0]           r_buf_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc   [FIFO_DEPTH];

  logic                  w_redirect, w_accept, w_resp, w_push, w_pop;
  logic [CNT_W:0]        w_inflight;
  logic [ADDR_WIDTH-1:0] w_resp_pc;
  logic [31:0]           w_push_data;

  // Requests are only issued in RUN and only while every in-flight word is
  // guaranteed a buffer slot, so a response can always be written.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req_valid = (r_state == S_RUN) && (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_pc;

  assign w_redirect = branch_taken && (r_state != S_BOOT);
  assign w_accept   = imem_req_valid && imem_req_ready;
  assign w_resp     = imem_resp_valid && (r_state != S_BOOT);
  assign w_push     = w_resp && (r_state == S_RUN) && !w_redirect;
  assign w_pop      = instr_valid && instr_ready;

  // In RUN the outstanding requests are the consecutive words just below the
  // PC, so the oldest one (the one now responding) sits outstanding*4 back.
  assign w_resp_pc = r_pc - ADDR_WIDTH'({r_outstanding, 2'b00});

`ifdef OPCODE_FILTER_EN
  logic r_buf_ill [FIFO_DEPTH];
  logic w_push_ill;

  // Screen opcodes on the way into the buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_push_data = imem_resp_data;
    w_push_ill  = 1'b0;
    case (imem_resp_data[6:0])
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: ;
      default: begin
        w_push_data = 32'h0000_0033;
        w_push_ill  = 1'b1;
      end
    endcase
  end

  // Flag storage travels with the buffered word.
  always_ff @(posedge clk) begin
    if (w_push) r_buf_ill[r_wr_ptr] <= w_push_ill;
  end

  assign illegal_instr = instr_valid && r_buf_ill[r_rd_ptr];
`else
  assign w_push_data = imem_resp_data;
`endif

  // Next PC, outstanding count and FSM state.
  always_comb begin
    w_pc_next          = r_pc;
    w_outstanding_next = r_outstanding;
    w_state_next       = r_state;
    if (w_accept) w_pc_next = r_pc + ADDR_WIDTH'(4);
    if (w_redirect) w_pc_next = branch_target & ~ADDR_WIDTH'(3);
    if (w_accept && !w_resp) w_outstanding_next = r_outstanding + CNT_W'(1);
    else if (!w_accept && w_resp) w_outstanding_next = r_outstanding - CNT_W'(1);
    case (r_state)
      S_BOOT:  w_state_next = S_RUN;
      S_RUN:   if (w_redirect && (w_outstanding_next != '0)) w_state_next = S_DRAIN;
      S_DRAIN: if (w_outstanding_next == '0) w_state_next = S_RUN;
      default: w_state_next = S_BOOT;
    endcase
  end

  // State register for FSM, PC and outstanding-request counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_outstanding <= w_outstanding_next;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage for word and its PC.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // visible through the reset-controlled count, and the outputs are forced
    // to zero while the buffer is empty.
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= w_push_data;
      r_buf_pc[r_wr_ptr]   <= w_resp_pc;
    end
  end

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_buf_data[r_rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign opcode      = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: in-order memory model with programmable
// latency, and a scoreboard of expected {pc, word} entries pushed when a
// response is presented and popped when decode consumes the head.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;
`ifdef OPCODE_FILTER_EN
  logic        illegal_instr;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .opcode          (opcode)
`ifdef OPCODE_FILTER_EN
    ,
    .illegal_instr   (illegal_instr)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  req_t        reqq[$];
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          n_acc = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] resp_addr, resp_word;
  int          resp_ep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: a legal R-type word tagged with its address, or the
  // directed words used for the opcode screen.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == 32'h0) return 32'h0000_0013;
    if (ovr_en && a == 32'h4) return 32'h0000_2003;
    return {a[26:2], 7'b0110011};
  endfunction

  function automatic exp_t expect_of(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc   = pc;
    e.data = w;
    e.ill  = 1'b0;
`ifdef OPCODE_FILTER_EN
    if (!(w[6:0] inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011})) begin
      e.data = 32'h0000_0033;
      e.ill  = 1'b1;
    end
`endif
    return e;
  endfunction

  // One clock cycle: observe handshakes mid-cycle, update the model, then
  // present the next memory response just after the edge.
  task automatic tick();
    exp_t e;
    req_t r;
    @(negedge clk);
    if (reset) begin
      reqq.delete();
      sb.delete();
      model_pc = 32'h0;
      epoch++;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, model_pc);
        r.addr = imem_req_addr;
        r.due  = cyc + lat;
        r.ep   = epoch;
        reqq.push_back(r);
        model_pc += 32'h4;
        n_acc++;
      end
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          check("spurious_instr_valid", {31'b0, instr_valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.data);
          check("opcode", {25'b0, opcode}, {25'b0, e.data[6:0]});
`ifdef OPCODE_FILTER_EN
          check("illegal_instr", {31'b0, illegal_instr}, {31'b0, e.ill});
`endif
        end
      end
      if (branch_taken) begin
        epoch++;
        model_pc = branch_target & ~32'h3;
        sb.delete();
      end
      if (imem_resp_valid && resp_ep == epoch) sb.push_back(expect_of(resp_addr, resp_word));
    end
    @(posedge clk);
    cyc++;
    #1;
    branch_taken = 1'b0;
    if (!reset && reqq.size() != 0 && reqq[0].due <= cyc) begin
      r = reqq.pop_front();
      resp_addr = r.addr;
      resp_ep   = r.ep;
      resp_word = mem_word(r.addr);
      imem_resp_valid = 1'b1;
      imem_resp_data  = resp_word;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    lat            = 1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) check(tag, {31'b0, instr_valid}, 32'h1);
  endtask

  // Reach cycle 5 with a request for 0x8 being accepted while the response
  // for 0x4 arrives (one ready stall spaces the first two requests).
  task automatic setup_coincident();
    do_reset();
    instr_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    check("t4_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("t4_req_addr", imem_req_addr, 32'h8);
    check("t4_instr_valid", {31'b0, instr_valid}, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick();
    check("t4_drain_req", {31'b0, imem_req_valid}, 32'h0);
    check("t4_drain_valid", {31'b0, instr_valid}, 32'h0);
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    branch_taken    = 1'b0;
    branch_target   = 32'h0;
    imem_req_ready  = 1'b1;
    instr_ready     = 1'b0;

    // Reset state.
    do_reset();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_opcode", {25'b0, opcode}, 32'h0);
`ifdef OPCODE_FILTER_EN
    check("rst_illegal", {31'b0, illegal_instr}, 32'h0);
`endif

    // 1: streaming fetch, first word three cycles after reset release.
    instr_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_valid_latency", 32'(n), 32'd3);
    check("first_pc", instr_pc, 32'h0);
    check("first_opcode", {25'b0, opcode}, 32'h33);
    repeat (12) tick();

    // 2: decode stalled; only FIFO_DEPTH requests go out, head holds.
    do_reset();
    n_acc = 0;
    repeat (10) tick();
    check("stall_req_count", 32'(n_acc), 32'd2);
    check("stall_valid", {31'b0, instr_valid}, 32'h1);
    check("stall_pc", instr_pc, 32'h0);
    check("full_req_withheld", {31'b0, imem_req_valid}, 32'h0);
    tick();
    check("stall_pc_stable", instr_pc, 32'h0);
    check("stall_instr_stable", instr, 32'h0000_0033);
    instr_ready = 1'b1;
    tick();
    check("release_valid", {31'b0, instr_valid}, 32'h1);
    check("release_pc", instr_pc, 32'h4);
    repeat (10) tick();

    // 3: redirect with two requests outstanding.
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    repeat (3) tick();
    check("t3_outstanding", 32'(reqq.size()), 32'd2);
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    tick();
    lat = 1;
    check("t3_drain_req0", {31'b0, imem_req_valid}, 32'h0);
    check("t3_drain_valid0", {31'b0, instr_valid}, 32'h0);
    tick();
    check("t3_drain_req1", {31'b0, imem_req_valid}, 32'h0);
    check("t3_drain_valid1", {31'b0, instr_valid}, 32'h0);
    tick();
    check("t3_resume_req", {31'b0, imem_req_valid}, 32'h1);
    check("t3_resume_addr", imem_req_addr, 32'h100);
    wait_valid("t3_timeout");
    check("t3_first_pc", instr_pc, 32'h100);
    repeat (6) tick();

    // 4: redirect coinciding with a request accept and a response.
    setup_coincident();
    tick();
    check("t4_resume_req", {31'b0, imem_req_valid}, 32'h1);
    check("t4_resume_addr", imem_req_addr, 32'h200);
    wait_valid("t4_timeout");
    check("t4_first_pc", instr_pc, 32'h200);
    repeat (6) tick();

    // 5: reset while draining with one request outstanding.
    setup_coincident();
    reset = 1'b1;
    tick();
    check("t5_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("t5_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("t5_instr", instr, 32'h0);
    check("t5_instr_pc", instr_pc, 32'h0);
    check("t5_opcode", {25'b0, opcode}, 32'h0);
    reset = 1'b0;
    tick();
    check("t5_boot_done_req", {31'b0, imem_req_valid}, 32'h1);
    check("t5_boot_done_addr", imem_req_addr, 32'h0);
    repeat (6) tick();

    // 6: opcode screen (pass-through when the filter is not built).
    do_reset();
    ovr_en = 1'b1;
    wait_valid("t6_timeout");
`ifdef OPCODE_FILTER_EN
    check("t6_instr_filtered", instr, 32'h0000_0033);
    check("t6_illegal_set", {31'b0, illegal_instr}, 32'h1);
`else
    check("t6_instr_passed", instr, 32'h0000_0013);
`endif
    instr_ready = 1'b1;
    tick();
    check("t6_load_instr", instr, 32'h0000_2003);
`ifdef OPCODE_FILTER_EN
    check("t6_illegal_clear", {31'b0, illegal_instr}, 32'h0);
`endif
    ovr_en = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1);
  end

endmodule
